// File: rtl/gpreg_pkg.sv
// rtl/gpreg_pkg.sv - shared widths and grant-source encodings for the GPR writeback scheduler
//
// Purpose: common constants for gpreg_wb_sched and its round-robin arbiter.
//   XLEN    write-port data width
//   REG_AW  register address width
//   NREG    number of architectural registers (2**REG_AW)
//   CNT_W   outstanding-load counter width (holds MAX_LOADS up to 15)
//   SRC_ALU / SRC_LSU  writeback source encodings, also the arbiter pointer values
package gpreg_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 1 << REG_AW;
  localparam int CNT_W  = 4;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;
endpackage

// File: rtl/wb_rr_arb.sv
// rtl/wb_rr_arb.sv - two-way round-robin arbiter for the register-file write port
//
// Purpose: picks one of the ALU / LSU writeback requests each cycle.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   alu_valid    ALU writeback request
//   lsu_valid    LSU writeback request
//   alu_gnt      ALU granted (combinational)
//   lsu_gnt      LSU granted (combinational)
//   ptr          side favoured on the next contested cycle (SRC_ALU / SRC_LSU)
module wb_rr_arb
  import gpreg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_gnt,
  output logic lsu_gnt,
  output logic ptr
);

  always_comb begin
    alu_gnt = alu_valid & (!lsu_valid | (ptr == SRC_ALU));
    lsu_gnt = lsu_valid & (!alu_valid | (ptr == SRC_LSU));
  end

  // The pointer only moves when both sides competed, so a lone requester
  // never steals the other side's next turn.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= SRC_LSU;
    end else if (alu_valid & lsu_valid) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/gpreg_wb_sched.sv
// rtl/gpreg_wb_sched.sv - GPR scoreboard, load limiter and shared write-port scheduler
//
// Purpose: gates issue on RAW/WAW hazards and on the outstanding-load limit,
// and shares the register file's single write port between ALU and LSU.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   issue_valid/issue_ready        decode handshake
//   issue_rs1/rs2/rd, issue_rd_en  operand and destination addresses
//   issue_is_load                  instruction returns its result through the LSU
//   alu_wb_valid/ready/addr/data   ALU writeback request
//   lsu_wb_valid/ready/addr/data   LSU writeback request
//   rd_w/rd_addr/rd                registered register-file write port
//   busy                           scoreboard, bit 0 tied low
//   wb_err                         sticky writeback protocol error
module gpreg_wb_sched
  import gpreg_pkg::*;
#(
  parameter int MAX_LOADS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_rd_en,
  input  logic              issue_is_load,
  input  logic              alu_wb_valid,
  output logic              alu_wb_ready,
  input  logic [REG_AW-1:0] alu_wb_addr,
  input  logic [XLEN-1:0]   alu_wb_data,
  input  logic              lsu_wb_valid,
  output logic              lsu_wb_ready,
  input  logic [REG_AW-1:0] lsu_wb_addr,
  input  logic [XLEN-1:0]   lsu_wb_data,
  output logic              rd_w,
  output logic [REG_AW-1:0] rd_addr,
  output logic [XLEN-1:0]   rd,
  output logic [NREG-1:0]   busy,
  output logic              wb_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOADS);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [NREG-1:0]   busy_nxt;
  logic              hz;
  logic              accept;
  logic              arb_ptr;
  logic              gnt_src;
  logic              wb_fire;
  logic              wb_write;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;

  wb_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_wb_valid),
    .lsu_valid (lsu_wb_valid),
    .alu_gnt   (alu_wb_ready),
    .lsu_gnt   (lsu_wb_ready),
    .ptr       (arb_ptr)
  );

  always_comb begin
    hz = ((issue_rs1 != '0) & busy[issue_rs1])
       | ((issue_rs2 != '0) & busy[issue_rs2])
       | (issue_rd_en & (issue_rd != '0) & busy[issue_rd]);
    issue_ready = !hz & !(issue_is_load & (cnt == MAX_CNT));
    accept      = issue_valid & issue_ready;
  end

  // Source of this cycle's grant: the pointer decides only under contention.
  always_comb begin
    gnt_src  = (alu_wb_valid & lsu_wb_valid) ? arb_ptr
             : (lsu_wb_valid ? SRC_LSU : SRC_ALU);
    wb_fire  = alu_wb_ready | lsu_wb_ready;
    wb_addr  = (gnt_src == SRC_LSU) ? lsu_wb_addr : alu_wb_addr;
    wb_data  = (gnt_src == SRC_LSU) ? lsu_wb_data : alu_wb_data;
    // x0 writebacks are consumed without touching the register file.
    wb_write = wb_fire & (wb_addr != '0);
  end

  // Clear is applied after set so it wins if both ever hit the same bit.
  always_comb begin
    busy_nxt = busy;
    if (accept & issue_rd_en & (issue_rd != '0)) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    if (wb_write) begin
      busy_nxt[wb_addr] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = cnt;
    if (accept & issue_is_load & lsu_wb_ready) begin
      cnt_nxt = cnt;
    end else if (accept & issue_is_load) begin
      cnt_nxt = cnt + 1'b1;
    end else if (lsu_wb_ready & (cnt != '0)) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= '0;
      cnt     <= '0;
      rd_w    <= 1'b0;
      rd_addr <= '0;
      rd      <= '0;
      wb_err  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
      rd_w <= wb_write;
      if (wb_write) begin
        rd_addr <= wb_addr;
        rd      <= wb_data;
      end
      if ((wb_write & !busy[wb_addr]) | (lsu_wb_ready & (cnt == '0))) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule
